// File: rtl/imsic_msi_arb_pkg.sv
// Shared IMSIC definitions for the MSI write arbiter: holding-register FSM
// encodings and the default M-burst limit before a waiting S write is forced in.
package imsic_msi_arb_pkg;

  // Output register occupancy, tagged with the side that owns the held write.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_M = 2'd1,
    HOLD_S = 2'd2
  } arb_state_e;

  // Consecutive M grants tolerated while S is waiting (legal range 1..15).
  localparam int MAX_M_BURST_DEF = 4;

  // Width of the burst counter; sized to cover the full 1..15 range.
  localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/imsic_msi_arb_oreg.sv
// One-entry registered output slot. Loads a new write whenever it is empty
// or is being drained in the same cycle, so it sustains one write per cycle.
module imsic_msi_arb_oreg #(
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      load,
  input  logic                      drain,
  input  logic [AXI_ADDR_WIDTH-1:0] in_addr,
  input  logic [31:0]               in_data,
  output logic                      load_en,
  output logic                      out_vld,
  output logic [AXI_ADDR_WIDTH-1:0] out_addr,
  output logic [31:0]               out_data
);

  logic                      vld_q,  vld_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               data_q, data_d;

  // Slot can take a new entry when empty, or when the held one leaves this cycle.
  assign load_en = !vld_q || drain;

  // Next-state of the slot: load wins, otherwise drain empties it, otherwise hold.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (load) begin
      vld_d  = 1'b1;
      addr_d = in_addr;
      data_d = in_data;
    end else if (drain) begin
      vld_d  = 1'b0;
    end
  end

  // Slot registers; payload is cleared too so a reset never exposes a stale write.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rstn) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q;
  assign out_addr = addr_q;
  assign out_data = data_q;

endmodule

// File: rtl/imsic_msi_arb.sv
// MSI setipnum write arbiter between the M side and the S/VS side.
// M has priority, but after MAX_M_BURST consecutive M grants with S waiting,
// S is granted once. The chosen write is registered in a one-entry slot.
module imsic_msi_arb
  import imsic_msi_arb_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_M_BURST    = MAX_M_BURST_DEF
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      m_req_vld,
  input  logic [AXI_ADDR_WIDTH-1:0] m_req_addr,
  input  logic [31:0]               m_req_data,
  output logic                      m_req_rdy,
  input  logic                      s_req_vld,
  input  logic [AXI_ADDR_WIDTH-1:0] s_req_addr,
  input  logic [31:0]               s_req_data,
  output logic                      s_req_rdy,
  output logic                      out_wr,
  output logic                      out_sel_s,
  output logic [AXI_ADDR_WIDTH-1:0] out_waddr,
  output logic [31:0]               out_wdata,
  input  logic                      out_rdy,
  output logic                      arb_busy
);

  localparam logic [BURST_CNT_W-1:0] BURST_MAX = BURST_CNT_W'(MAX_M_BURST);

  arb_state_e               state_q, state_d;
  logic [BURST_CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

  logic                      load_en;
  logic                      grant_m, grant_s;
  logic                      accept_m, accept_s, load;
  logic                      drain;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]               sel_data;

  // Grant selection: S wins when alone or when M has used up its burst allowance.
  always_comb begin
    grant_s = s_req_vld && (!m_req_vld || (burst_cnt_q == BURST_MAX));
    grant_m = m_req_vld && !grant_s;
  end

  // Handshakes are masked during reset so nothing is accepted while rstn is low.
  assign m_req_rdy = rstn && load_en && grant_m;
  assign s_req_rdy = rstn && load_en && grant_s;
  assign accept_m  = m_req_vld && m_req_rdy;
  assign accept_s  = s_req_vld && s_req_rdy;
  assign load      = accept_m || accept_s;
  assign drain     = out_wr && out_rdy;
  assign sel_addr  = accept_s ? s_req_addr : m_req_addr;
  assign sel_data  = accept_s ? s_req_data : m_req_data;

  // Next FSM state and burst count, derived from this cycle's accept/drain.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    if (accept_s) begin
      state_d     = HOLD_S;
      burst_cnt_d = '0;
    end else if (accept_m) begin
      state_d = HOLD_M;
      if (!s_req_vld)                burst_cnt_d = '0;
      else if (burst_cnt_q < BURST_MAX) burst_cnt_d = burst_cnt_q + 1'b1;
    end else if (drain) begin
      state_d = IDLE;
    end
  end

  // FSM and burst counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  imsic_msi_arb_oreg #(
    .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH)
  ) u_oreg (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .drain    (drain),
    .in_addr  (sel_addr),
    .in_data  (sel_data),
    .load_en  (load_en),
    .out_vld  (out_wr),
    .out_addr (out_waddr),
    .out_data (out_wdata)
  );

  // The owning side of the held write comes straight from the FSM flop.
  assign out_sel_s = (state_q == HOLD_S);
  assign arb_busy  = out_wr;

endmodule

// File: tb/tb_imsic_msi_arb.sv
// Directed bench for imsic_msi_arb: reset, single M write, M/S burst fairness,
// downstream stall, S-only stream and reset while holding a write.
module tb_imsic_msi_arb;

  logic        clk;
  logic        rstn;
  logic        m_req_vld;
  logic [31:0] m_req_addr;
  logic [31:0] m_req_data;
  logic        m_req_rdy;
  logic        s_req_vld;
  logic [31:0] s_req_addr;
  logic [31:0] s_req_data;
  logic        s_req_rdy;
  logic        out_wr;
  logic        out_sel_s;
  logic [31:0] out_waddr;
  logic [31:0] out_wdata;
  logic        out_rdy;
  logic        arb_busy;

  int checks = 0;
  int errors = 0;

  imsic_msi_arb #(
    .AXI_ADDR_WIDTH (32),
    .MAX_M_BURST    (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .m_req_vld  (m_req_vld),
    .m_req_addr (m_req_addr),
    .m_req_data (m_req_data),
    .m_req_rdy  (m_req_rdy),
    .s_req_vld  (s_req_vld),
    .s_req_addr (s_req_addr),
    .s_req_data (s_req_data),
    .s_req_rdy  (s_req_rdy),
    .out_wr     (out_wr),
    .out_sel_s  (out_sel_s),
    .out_waddr  (out_waddr),
    .out_wdata  (out_wdata),
    .out_rdy    (out_rdy),
    .arb_busy   (arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge (inputs driven and outputs sampled here).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; out_rdy = 1'b1;
    m_req_vld = 1'b1; m_req_addr = 32'h10; m_req_data = 32'h1;
    s_req_vld = 1'b1; s_req_addr = 32'h20; s_req_data = 32'h2;
    #3;
    checks++; if (out_wr !== 1'b0)     begin errors++; $display("FAIL reset_out_wr got %b exp 0", out_wr); end
    checks++; if (out_sel_s !== 1'b0)  begin errors++; $display("FAIL reset_sel got %b exp 0", out_sel_s); end
    checks++; if (out_waddr !== 32'h0) begin errors++; $display("FAIL reset_waddr got %h exp 0", out_waddr); end
    checks++; if (out_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", out_wdata); end
    checks++; if (m_req_rdy !== 1'b0)  begin errors++; $display("FAIL reset_m_rdy got %b exp 0", m_req_rdy); end
    checks++; if (s_req_rdy !== 1'b0)  begin errors++; $display("FAIL reset_s_rdy got %b exp 0", s_req_rdy); end
    checks++; if (arb_busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", arb_busy); end
    step();
    step();
    checks++; if (out_wr !== 1'b0)     begin errors++; $display("FAIL reset_held_out_wr got %b exp 0", out_wr); end
    m_req_vld = 1'b0; s_req_vld = 1'b0;
    rstn = 1'b1;
  endtask

  // Single M write presented right after reset release: accepted on the first edge.
  task automatic test_single();
    m_req_vld = 1'b1; m_req_addr = 32'h0000_1000; m_req_data = 32'd5; out_rdy = 1'b1;
    #1;
    checks++; if (m_req_rdy !== 1'b1) begin errors++; $display("FAIL single_m_rdy got %b exp 1", m_req_rdy); end
    checks++; if (s_req_rdy !== 1'b0) begin errors++; $display("FAIL single_s_rdy got %b exp 0", s_req_rdy); end
    step();
    m_req_vld = 1'b0;
    checks++; if (out_wr !== 1'b1)           begin errors++; $display("FAIL single_out_wr got %b exp 1", out_wr); end
    checks++; if (out_sel_s !== 1'b0)        begin errors++; $display("FAIL single_sel got %b exp 0", out_sel_s); end
    checks++; if (out_waddr !== 32'h1000)    begin errors++; $display("FAIL single_waddr got %h exp 1000", out_waddr); end
    checks++; if (out_wdata !== 32'd5)       begin errors++; $display("FAIL single_wdata got %h exp 5", out_wdata); end
    checks++; if (arb_busy !== 1'b1)         begin errors++; $display("FAIL single_busy got %b exp 1", arb_busy); end
    step();
    checks++; if (out_wr !== 1'b0)           begin errors++; $display("FAIL single_drain got %b exp 0", out_wr); end
    checks++; if (arb_busy !== 1'b0)         begin errors++; $display("FAIL single_busy_drain got %b exp 0", arb_busy); end
  endtask

  // Both sides valid every cycle with MAX_M_BURST=4: M,M,M,M,S repeating.
  task automatic test_priority();
    logic [9:0] exp_s;
    int         exp_cnt [10];
    exp_s   = 10'b10000_10000; // bit i = S granted in iteration i
    exp_cnt = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      m_req_vld = 1'b1; m_req_addr = 32'h3000 + 32'(i); m_req_data = 32'h100 + 32'(i);
      s_req_vld = 1'b1; s_req_addr = 32'h4000 + 32'(i); s_req_data = 32'h200 + 32'(i);
      #1;
      checks++; if (s_req_rdy !== exp_s[i])  begin errors++; $display("FAIL prio_s_rdy[%0d] got %b exp %b", i, s_req_rdy, exp_s[i]); end
      checks++; if (m_req_rdy !== !exp_s[i]) begin errors++; $display("FAIL prio_m_rdy[%0d] got %b exp %b", i, m_req_rdy, !exp_s[i]); end
      step();
      checks++; if (out_wr !== 1'b1)         begin errors++; $display("FAIL prio_out_wr[%0d] got %b exp 1", i, out_wr); end
      checks++; if (out_sel_s !== exp_s[i])  begin errors++; $display("FAIL prio_sel[%0d] got %b exp %b", i, out_sel_s, exp_s[i]); end
      checks++; if (out_wdata !== (exp_s[i] ? 32'h200 + 32'(i) : 32'h100 + 32'(i)))
        begin errors++; $display("FAIL prio_wdata[%0d] got %h exp %h", i, out_wdata, exp_s[i] ? 32'h200 + 32'(i) : 32'h100 + 32'(i)); end
      checks++; if (dut.burst_cnt_q !== 4'(exp_cnt[i]))
        begin errors++; $display("FAIL prio_burst_cnt[%0d] got %0d exp %0d", i, dut.burst_cnt_q, exp_cnt[i]); end
    end
    m_req_vld = 1'b0; s_req_vld = 1'b0;
    step();
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL prio_drain got %b exp 0", out_wr); end
  endtask

  // S write stalled 6 cycles by out_rdy=0, then drained while the next S loads.
  task automatic test_stall();
    s_req_vld = 1'b1; s_req_addr = 32'h0000_2000; s_req_data = 32'hAB; out_rdy = 1'b0;
    #1;
    checks++; if (s_req_rdy !== 1'b1) begin errors++; $display("FAIL stall_first_s_rdy got %b exp 1", s_req_rdy); end
    step();
    s_req_addr = 32'h0000_2004; s_req_data = 32'hCD;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (s_req_rdy !== 1'b0 || m_req_rdy !== 1'b0)
        begin errors++; $display("FAIL stall_rdy[%0d] got s=%b m=%b exp 0 0", i, s_req_rdy, m_req_rdy); end
      checks++; if (out_wr !== 1'b1 || out_sel_s !== 1'b1 || out_waddr !== 32'h2000 || out_wdata !== 32'hAB)
        begin errors++; $display("FAIL stall_hold[%0d] got wr=%b sel=%b a=%h d=%h exp 1 1 2000 ab", i, out_wr, out_sel_s, out_waddr, out_wdata); end
      step();
    end
    out_rdy = 1'b1;
    #1;
    checks++; if (s_req_rdy !== 1'b1) begin errors++; $display("FAIL stall_reload_rdy got %b exp 1", s_req_rdy); end
    step();
    s_req_vld = 1'b0;
    checks++; if (out_wr !== 1'b1 || out_waddr !== 32'h2004 || out_wdata !== 32'hCD)
      begin errors++; $display("FAIL stall_next got wr=%b a=%h d=%h exp 1 2004 cd", out_wr, out_waddr, out_wdata); end
    step();
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", out_wr); end
  endtask

  // Only S valid: three consecutive S grants, burst counter untouched.
  task automatic test_s_only();
    out_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_req_vld = 1'b1; s_req_addr = 32'h5000 + 32'(4 * i); s_req_data = 32'h50 + 32'(i);
      #1;
      checks++; if (s_req_rdy !== 1'b1 || m_req_rdy !== 1'b0)
        begin errors++; $display("FAIL sonly_rdy[%0d] got s=%b m=%b exp 1 0", i, s_req_rdy, m_req_rdy); end
      step();
      checks++; if (out_wr !== 1'b1 || out_sel_s !== 1'b1 || out_waddr !== 32'h5000 + 32'(4 * i) || out_wdata !== 32'h50 + 32'(i))
        begin errors++; $display("FAIL sonly_out[%0d] got wr=%b sel=%b a=%h d=%h", i, out_wr, out_sel_s, out_waddr, out_wdata); end
      checks++; if (dut.burst_cnt_q !== 4'd0)
        begin errors++; $display("FAIL sonly_burst_cnt[%0d] got %0d exp 0", i, dut.burst_cnt_q); end
    end
    s_req_vld = 1'b0;
    step();
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL sonly_drain got %b exp 0", out_wr); end
  endtask

  // Reset pulse while holding an S write: cleared at once, never replayed.
  task automatic test_reset_mid();
    s_req_vld = 1'b1; s_req_addr = 32'h0000_2000; s_req_data = 32'h77; out_rdy = 1'b0;
    step();
    checks++; if (out_wr !== 1'b1 || out_sel_s !== 1'b1)
      begin errors++; $display("FAIL rmid_hold got wr=%b sel=%b exp 1 1", out_wr, out_sel_s); end
    #1 rstn = 1'b0;
    #1;
    checks++; if (out_wr !== 1'b0 || arb_busy !== 1'b0 || out_sel_s !== 1'b0)
      begin errors++; $display("FAIL rmid_async got wr=%b busy=%b sel=%b exp 0 0 0", out_wr, arb_busy, out_sel_s); end
    checks++; if (s_req_rdy !== 1'b0) begin errors++; $display("FAIL rmid_s_rdy got %b exp 0", s_req_rdy); end
    s_req_vld = 1'b0;
    #1 rstn = 1'b1;
    m_req_vld = 1'b1; m_req_addr = 32'h0000_4000; m_req_data = 32'd7; out_rdy = 1'b1;
    #1;
    checks++; if (m_req_rdy !== 1'b1) begin errors++; $display("FAIL rmid_first_rdy got %b exp 1", m_req_rdy); end
    step();
    m_req_vld = 1'b0;
    checks++; if (out_wr !== 1'b1 || out_sel_s !== 1'b0 || out_waddr !== 32'h4000 || out_wdata !== 32'd7)
      begin errors++; $display("FAIL rmid_no_replay got wr=%b sel=%b a=%h d=%h exp 1 0 4000 7", out_wr, out_sel_s, out_waddr, out_wdata); end
    step();
    checks++; if (out_wr !== 1'b0) begin errors++; $display("FAIL rmid_drain got %b exp 0", out_wr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_stall();
    test_s_only();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imsic_msi_arb.md
IMSIC_MSI_ARB -- requirements
Module: imsic_msi_arb

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, width of the request and output write addresses.
REQ-002 SHALL have parameter MAX_M_BURST, default 4, range 1..15: the maximum number of consecutive M grants allowed while S is waiting.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 m_req_vld  input  1  M-side setipnum write request valid.
REQ-006 m_req_addr  input  AXI_ADDR_WIDTH  M-side write address.
REQ-007 m_req_data  input  32  M-side write data.
REQ-008 m_req_rdy  output  1  M-side request accepted this cycle.
REQ-009 s_req_vld  input  1  S/VS-side write request valid.
REQ-010 s_req_addr  input  AXI_ADDR_WIDTH  S/VS-side write address.
REQ-011 s_req_data  input  32  S/VS-side write data.
REQ-012 s_req_rdy  output  1  S/VS-side request accepted this cycle.
REQ-013 out_wr  output  1  granted write valid toward the regmap.
REQ-014 out_sel_s  output  1  granted source: 1 = S/VS, 0 = M; drives the regmap msi_s_busy input.
REQ-015 out_waddr  output  AXI_ADDR_WIDTH  granted address.
REQ-016 out_wdata  output  32  granted data.
REQ-017 out_rdy  input  1  downstream accepts out_wr this cycle (regmap FIFO not full).
REQ-018 arb_busy  output  1  output register holds an undrained write.

Function
REQ-019 Output register empty/full rule: the register SHALL be loadable (load_en) when it is empty, or when it is full and out_wr & out_rdy in the same cycle.
REQ-020 A request SHALL be accepted only when vld & rdy; m_req_rdy and s_req_rdy SHALL be combinational (load_en & grant to that side) and never both 1.
REQ-021 Latency: a request accepted in cycle N SHALL appear on out_wr/out_sel_s/out_waddr/out_wdata in cycle N+1.
REQ-022 While out_wr=1 and out_rdy=0, out_sel_s, out_waddr and out_wdata SHALL hold stable and out_wr SHALL stay 1.
REQ-023 When out_wr & out_rdy and no request is loaded in that cycle, out_wr SHALL fall to 0 in the next cycle.
REQ-024 Back-to-back operation: with out_rdy=1 held, one request per cycle SHALL be sustained.
REQ-025 FSM states:
- IDLE: register empty.
- HOLD_M: register full with an M write.
- HOLD_S: register full with an S write.
REQ-026 FSM transitions:
- Any state moves to HOLD_M or HOLD_S on a load from that side.
- HOLD_x moves to IDLE on a drain with no load.
- The state is unchanged otherwise.
REQ-027 Priority:
- Only one side valid: that side is granted.
- Both valid: M is granted, unless burst_cnt == MAX_M_BURST, in which case S is granted.
REQ-028 burst_cnt (4-bit, saturating at MAX_M_BURST) update:
- Increments on an M accept while s_req_vld=1.
- Clears to 0 on any S accept.
- Clears to 0 on an M accept with s_req_vld=0.
- Holds otherwise.
REQ-029 Requests SHALL NOT be dropped or reordered within one side; a vld held without rdy SHALL be granted within MAX_M_BURST+1 load opportunities.
REQ-030 arb_busy SHALL equal out_wr.
REQ-031 The block SHALL perform no address legality checks; illegal addresses are forwarded unchanged.

Reset
REQ-032 rstn low SHALL immediately force:
- out_wr=0, out_sel_s=0, out_waddr=0, out_wdata=0;
- FSM=IDLE, burst_cnt=0;
- m_req_rdy=0, s_req_rdy=0.
REQ-033 Reset asserted mid-operation SHALL discard any held write; the write SHALL NOT be replayed after reset release.
REQ-034 The first acceptance SHALL be possible in the first clock edge after rstn deasserts.

Structure
REQ-035 FSM state encodings (IDLE=0, HOLD_M=1, HOLD_S=2) and the MAX_M_BURST default SHALL reside in the shared IMSIC define package/header.
REQ-036 A single sub-module, imsic_msi_arb_oreg (one-entry registered output slot with load/drain), SHALL hold the payload; the arbitration, FSM and burst counter SHALL live in imsic_msi_arb.
REQ-037 out_sel_s, out_wr, out_waddr and out_wdata SHALL connect directly to the regmap msi_s_busy, reg_wr, reg_waddr and reg_wdata of the selected side.

Verification
REQ-038 Single M request, addr 0x0000_1000, data 5, out_rdy=1 -> m_req_rdy=1 in cycle N; in cycle N+1 out_wr=1, out_sel_s=0, out_waddr=0x1000, out_wdata=5; out_wr=0 in N+2.
REQ-039 Both valid continuously, MAX_M_BURST=4, out_rdy=1 -> grant sequence M,M,M,M,S,M,M,M,M,S; burst_cnt returns to 0 after each S.
REQ-040 S write 0x0000_2000 held with out_rdy=0 for 6 cycles -> out_* stable for 6 cycles, no rdy to either side; drained in the cycle out_rdy=1, next request loaded in that same cycle.
REQ-041 Only s_req_vld=1, 3 requests, out_rdy=1 -> 3 consecutive S grants, burst_cnt stays 0, out_sel_s=1 throughout.
REQ-042 rstn pulsed low while HOLD_S with out_rdy=0 -> out_wr=0 asynchronously; after release, no replay; next request accepted on the first edge.
